// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits
// that share one hex-to-segment decoder. A double-buffered display word is held
// internally: loads land in the pending buffer, and the pending buffer is copied
// into the active buffer only at a frame boundary, so a frame never tears.
//
// Each digit owns a slot of CLK_DIV cycles. A slot opens with BLANK_CYC cycles
// in which every anode is off while the decoder input already shows the slot's
// nibble. The anode is then enabled for the rest of the slot if that digit is
// enabled. Disabled digits still consume their slot.
//
// Every output comes straight from a flop. The output flops are loaded from the
// next-state values of cnt/idx/active, so in any cycle the outputs describe the
// cnt/idx held in the registers during that same cycle.
//
// Ports
//   clk         in   1             system clock, rising edge
//   rst         in   1             asynchronous active-high reset
//   load        in   1             1-cycle strobe, captures data_in/dp_in/en_in
//   data_in     in   4*NUM_DIGITS  nibble k = digit k value (digit 0 = LSBs)
//   dp_in       in   NUM_DIGITS    decimal point per digit, 1 = lit
//   en_in       in   NUM_DIGITS    digit enable per digit, 0 = kept dark
//   bin_data    out  4             nibble for the shared decoder
//   dp_n        out  1             decimal point, active-low
//   dig_sel_n   out  NUM_DIGITS    anode selects, active-low, one-hot or none
//   frame_tick  out  1             pulse on the last cycle of the last digit
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    output logic [3:0]              bin_data,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic                    frame_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    // scan position
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;

    // display buffers
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_en;
    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_en;

    // output flops
    logic [3:0]              r_bin_data;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_dig_sel_n;
    logic                    r_frame_tick;

    // next-state values
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [IDX_W-1:0]        w_idx_next;
    logic [4*NUM_DIGITS-1:0] w_pend_data_next;
    logic [NUM_DIGITS-1:0]   w_pend_dp_next;
    logic [NUM_DIGITS-1:0]   w_pend_en_next;
    logic [4*NUM_DIGITS-1:0] w_act_data_next;
    logic [NUM_DIGITS-1:0]   w_act_dp_next;
    logic [NUM_DIGITS-1:0]   w_act_en_next;
    phase_t                  w_phase_next;
    logic [3:0]              w_bin_next;
    logic                    w_dp_n_next;
    logic [NUM_DIGITS-1:0]   w_sel_next;
    logic                    w_tick_next;

    // Counter, digit index and buffer transfer.
    always_comb begin
        w_slot_end  = (r_cnt == CNT_LAST);
        w_frame_end = w_slot_end && (r_idx == IDX_LAST);

        w_cnt_next = w_slot_end ? '0 : r_cnt + CNT_W'(1);

        w_idx_next = r_idx;
        if (w_slot_end) begin
            w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end

        w_pend_data_next = r_pend_data;
        w_pend_dp_next   = r_pend_dp;
        w_pend_en_next   = r_pend_en;
        if (load) begin
            w_pend_data_next = data_in;
            w_pend_dp_next   = dp_in;
            w_pend_en_next   = en_in;
        end

        // Taking the post-load pending value means a load on the boundary
        // cycle goes straight to the display.
        w_act_data_next = r_act_data;
        w_act_dp_next   = r_act_dp;
        w_act_en_next   = r_act_en;
        if (w_frame_end) begin
            w_act_data_next = w_pend_data_next;
            w_act_dp_next   = w_pend_dp_next;
            w_act_en_next   = w_pend_en_next;
        end
    end

    // Output values for the next cycle, derived from the next scan position.
    always_comb begin
        w_phase_next = (w_cnt_next < BLANK_END) ? PH_BLANK : PH_DRIVE;
        w_bin_next   = '0;
        w_dp_n_next  = 1'b1;
        w_sel_next   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_next == IDX_W'(k)) begin
                // Nibble and dp are presented for the whole slot so the
                // decoder has settled before the anode turns on.
                w_bin_next  = w_act_data_next[4*k +: 4];
                w_dp_n_next = ~w_act_dp_next[k];
                if ((w_phase_next == PH_DRIVE) && w_act_en_next[k]) begin
                    w_sel_next[k] = 1'b0;
                end
            end
        end
        w_tick_next = (w_cnt_next == CNT_LAST) && (w_idx_next == IDX_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_en    <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '0;
            r_bin_data   <= '0;
            r_dp_n       <= 1'b1;
            r_dig_sel_n  <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_pend_data  <= w_pend_data_next;
            r_pend_dp    <= w_pend_dp_next;
            r_pend_en    <= w_pend_en_next;
            r_act_data   <= w_act_data_next;
            r_act_dp     <= w_act_dp_next;
            r_act_en     <= w_act_en_next;
            r_bin_data   <= w_bin_next;
            r_dp_n       <= w_dp_n_next;
            r_dig_sel_n  <= w_sel_next;
            r_frame_tick <= w_tick_next;
        end
    end

    assign bin_data   = r_bin_data;
    assign dp_n       = r_dp_n;
    assign dig_sel_n  = r_dig_sel_n;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Two instances share clock and reset:
//   dut0: NUM_DIGITS=4, CLK_DIV=8, BLANK_CYC=2
//   dut1: NUM_DIGITS=1, CLK_DIV=4, BLANK_CYC=1
// Cycle t counts from reset release (t=0 is the cycle in which rst drops).
// The reference model keeps a log of every load with the cycle it was issued;
// the word shown in a frame starting at cycle fs is the last load issued in a
// cycle before fs (all zeros if none). The rest follows from t alone.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    typedef struct packed {
        int          cyc;
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
    } rec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0 signals
    logic        load0 = 1'b0;
    logic [15:0] data0 = '0;
    logic [3:0]  dp0   = '0;
    logic [3:0]  en0   = '0;
    logic [3:0]  bin0;
    logic        dpn0;
    logic [3:0]  sel0;
    logic        tick0;

    // dut1 signals
    logic        load1 = 1'b0;
    logic [3:0]  data1 = '0;
    logic [0:0]  dp1   = '0;
    logic [0:0]  en1   = '0;
    logic [3:0]  bin1;
    logic        dpn1;
    logic [0:0]  sel1;
    logic        tick1;

    seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2)) dut0 (
        .clk(clk), .rst(rst), .load(load0), .data_in(data0), .dp_in(dp0),
        .en_in(en0), .bin_data(bin0), .dp_n(dpn0), .dig_sel_n(sel0),
        .frame_tick(tick0)
    );

    seg_scan_ctrl #(.NUM_DIGITS(1), .CLK_DIV(4), .BLANK_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .data_in(data1), .dp_in(dp1),
        .en_in(en1), .bin_data(bin1), .dp_n(dpn1), .dig_sel_n(sel1),
        .frame_tick(tick1)
    );

    // scoreboard
    logic [9:0] exp_q[$];   // {bin, dp_n, dig_sel_n, frame_tick} of dut0
    logic [6:0] exp1_q[$];  // same fields for dut1
    rec_t       log0[$];
    rec_t       log1[$];
    int         t      = 0;
    bit         mon_en = 1'b0;
    bit         done   = 1'b0;
    int         checks = 0;
    int         errors = 0;

    function automatic rec_t find_word(input int which, input int fs);
        rec_t r;
        r = '0;
        if (which == 0) begin
            foreach (log0[i]) if (log0[i].cyc < fs) r = log0[i];
        end else begin
            foreach (log1[i]) if (log1[i].cyc < fs) r = log1[i];
        end
        return r;
    endfunction

    // ---------------- reference model: expected outputs of cycle t ----------
    task automatic push_expected();
        rec_t       w;
        int         d;
        int         pos;
        logic [3:0] bin;
        logic       dpn;
        logic [3:0] sel;
        logic       tk;
        logic [0:0] sel_1;

        w   = find_word(0, (t / 32) * 32);
        d   = (t % 32) / 8;
        pos = t % 8;
        bin = w.data[4*d +: 4];
        dpn = ~w.dp[d];
        sel = 4'hF;
        if (pos >= 2 && w.en[d]) sel[d] = 1'b0;
        tk  = ((t % 32) == 31);
        exp_q.push_back({bin, dpn, sel, tk});

        w     = find_word(1, (t / 4) * 4);
        pos   = t % 4;
        sel_1 = (pos >= 1 && w.en[0]) ? 1'b0 : 1'b1;
        exp1_q.push_back({w.data[3:0], ~w.dp[0], sel_1, ((t % 4) == 3)});
    endtask

    // ---------------- driver: inputs for cycle t ------------------------------
    task automatic drive_dut0();
        bit do_ld;
        do_ld = 1'b0;
        load0 = 1'b0;
        if (t == 5) begin
            data0 = 16'h1234; en0 = 4'hF; dp0 = 4'b0010; do_ld = 1'b1;
        end else if (t == 70) begin
            data0 = 16'($urandom); en0 = 4'b0101; dp0 = 4'($urandom_range(0, 15));
            do_ld = 1'b1;
        end else if (t == 95) begin
            data0 = 16'hABCD; en0 = 4'hF; dp0 = 4'b1000; do_ld = 1'b1;
        end else if (t >= 100) begin
            if (((t % 32) == 31 && $urandom_range(0, 1) == 1) ||
                $urandom_range(0, 11) == 0) begin
                data0 = 16'($urandom);
                en0   = 4'($urandom_range(0, 15));
                dp0   = 4'($urandom_range(0, 15));
                do_ld = 1'b1;
            end
        end
        if (do_ld) begin
            load0 = 1'b1;
            log0.push_back('{cyc: t, data: data0, dp: dp0, en: en0});
        end
    endtask

    task automatic drive_dut1();
        bit do_ld;
        do_ld = 1'b0;
        load1 = 1'b0;
        if (t == 0) begin
            data1 = 4'h7; dp1 = 1'b1; en1 = 1'b1; do_ld = 1'b1;
        end else if (t == 9) begin
            data1 = 4'hC; dp1 = 1'b0; en1 = 1'b1; do_ld = 1'b1;
        end else if (t >= 20 && $urandom_range(0, 5) == 0) begin
            data1 = 4'($urandom_range(0, 15));
            dp1   = 1'($urandom_range(0, 1));
            en1   = 1'($urandom_range(0, 1));
            do_ld = 1'b1;
        end
        if (do_ld) begin
            load1 = 1'b1;
            log1.push_back('{cyc: t, data: {12'h0, data1}, dp: {3'b0, dp1},
                             en: {3'b0, en1}});
        end
    endtask

    task automatic cycle_body();
        push_expected();
        drive_dut0();
        drive_dut1();
        mon_en = 1'b1;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        t   = 0;
        log0.delete();
        log1.delete();
        cycle_body();
    endtask

    // ---------------- stimulus -----------------------------------------------
    initial begin
        bit did_reset;
        int end_t;
        did_reset = 1'b0;
        end_t     = 0;
        repeat (3) @(posedge clk);
        #1;
        release_reset();
        forever begin
            @(posedge clk);
            #1;
            t++;
            if (!did_reset && t >= 600 && (t % 32) == 21) begin
                // Slot 2 is in its DRIVE phase here; reset lands mid-cycle.
                mon_en = 1'b0;
                load0  = 1'b0;
                load1  = 1'b0;
                #2;
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                did_reset = 1'b1;
                release_reset();
            end else if (did_reset && t >= 300) begin
                break;
            end else begin
                cycle_body();
            end
        end
        mon_en = 1'b0;
        load0  = 1'b0;
        load1  = 1'b0;
        done   = 1'b1;
        end_t  = t;
    end

    // ---------------- monitor / checker --------------------------------------
    task automatic cmp10(input string name, input logic [9:0] act, input logic [9:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0d got bin=%h dp_n=%b sel_n=%b tick=%b exp bin=%h dp_n=%b sel_n=%b tick=%b",
                     name, t, act[9:6], act[5], act[4:1], act[0],
                     exp_v[9:6], exp_v[5], exp_v[4:1], exp_v[0]);
        end
    endtask

    task automatic cmp7(input string name, input logic [6:0] act, input logic [6:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0d got bin=%h dp_n=%b sel_n=%b tick=%b exp bin=%h dp_n=%b sel_n=%b tick=%b",
                     name, t, act[6:3], act[2], act[1], act[0],
                     exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            // Reset state must be visible before the next rising edge.
            cmp10("reset_dut0", {bin0, dpn0, sel0, tick0}, {4'h0, 1'b1, 4'hF, 1'b0});
            cmp7("reset_dut1", {bin1, dpn1, sel1, tick1}, {4'h0, 1'b1, 1'b1, 1'b0});
        end else if (done) begin
            checks++;
            if (exp_q.size() != 0 || exp1_q.size() != 0) begin
                errors++;
                $display("FAIL drain left dut0=%0d dut1=%0d required 0",
                         exp_q.size(), exp1_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (mon_en) begin
            if (exp_q.size() == 0 || exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL underflow t=%0d dut0=%0d dut1=%0d required nonzero",
                         t, exp_q.size(), exp1_q.size());
            end else begin
                cmp10("scan_dut0", {bin0, dpn0, sel0, tick0}, exp_q.pop_front());
                cmp7("scan_dut1", {bin1, dpn1, sel1, tick1}, exp1_q.pop_front());
            end
        end
    end

    // Hard time limit in case the stimulus never sets done.
    initial begin
        #200000;
        $display("FAIL timeout t=%0d required completion", t);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $finish;
    end

endmodule
